// File: rtl/mandel_iter.sv
// mandel_iter: iteration controller for one Mandelbrot pixel.
// It sequences one shared multiplier through x*x, y*y and x*y. Then it forms
// z <- z^2 + c and checks for escape, overflow or the iteration limit.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   io_start              begin a pixel (sampled only when idle)
//   io_cx, io_cy          c, signed fixed point with 4 fractional bits
//   io_iter_max           iteration limit (0 finishes at once)
//   io_busy, io_done      busy level, one-cycle completion pulse
//   io_iter, io_escaped   completed iterations, escape/overflow flag
//   mul_start/a/b         request to the shared multiplier
//   mul_done/ovf/val      multiplier response (rounded, already >> 4)
//
// state  | meaning
// IDLE   | waiting for io_start
// MXX    | issue x*x
// WXX    | wait for x*x result
// MYY    | issue y*y
// WYY    | wait for y*y result
// MXY    | issue x*y
// WXY    | wait for x*y result
// UPDATE | form z^2 + c, test escape and limit
module mandel_iter #(
  parameter int ITERW = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  output logic             io_busy,
  output logic             io_done,
  input  logic [24:0]      io_cx,
  input  logic [24:0]      io_cy,
  input  logic [ITERW-1:0] io_iter_max,
  output logic [ITERW-1:0] io_iter,
  output logic             io_escaped,
  output logic             mul_start,
  output logic [24:0]      mul_a,
  output logic [24:0]      mul_b,
  input  logic             mul_done,
  input  logic             mul_ovf,
  input  logic [24:0]      mul_val
);

  typedef enum logic [2:0] {
    IDLE, MXX, WXX, MYY, WYY, MXY, WXY, UPDATE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [24:0]      r_cx, r_cy, r_x, r_y, r_xx, r_yy, r_xy;
  logic [ITERW-1:0] r_iter_max, r_iter;
  logic             r_ovf, r_busy, r_done, r_escaped;

  logic signed [26:0] w_xx_e, w_yy_e, w_xy2_e, w_cx_e, w_cy_e;
  logic signed [26:0] w_mag, w_nx, w_ny;
  logic               w_nx_out, w_ny_out, w_escape, w_last;
  logic [ITERW-1:0]   w_iter_inc;

  // All 25-bit terms are sign-extended to 27 bits, so the sums cannot wrap.
  assign w_xx_e  = {{2{r_xx[24]}}, r_xx};
  assign w_yy_e  = {{2{r_yy[24]}}, r_yy};
  assign w_xy2_e = {r_xy[24], r_xy, 1'b0};
  assign w_cx_e  = {{2{r_cx[24]}}, r_cx};
  assign w_cy_e  = {{2{r_cy[24]}}, r_cy};

  assign w_mag = w_xx_e + w_yy_e;
  assign w_nx  = w_xx_e - w_yy_e + w_cx_e;
  assign w_ny  = w_xy2_e + w_cy_e;

  // A value fits in 25 bits only when its top three bits agree.
  assign w_nx_out = (w_nx[26:24] != 3'b000) && (w_nx[26:24] != 3'b111);
  assign w_ny_out = (w_ny[26:24] != 3'b000) && (w_ny[26:24] != 3'b111);

  // A magnitude of exactly 4.0 (64) stays inside the set.
  assign w_escape   = r_ovf || (w_mag > 27'sd64) || w_nx_out || w_ny_out;
  assign w_iter_inc = r_iter + 1'b1;
  assign w_last     = (w_iter_inc == r_iter_max);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mul_start   = 1'b0;
    mul_a       = '0;
    mul_b       = '0;
    case (r_state)
      IDLE: begin
        if (io_start && (io_iter_max != '0)) w_state_nxt = MXX;
      end
      MXX: begin
        mul_start   = 1'b1;
        mul_a       = r_x;
        mul_b       = r_x;
        w_state_nxt = WXX;
      end
      WXX: begin
        mul_a = r_x;
        mul_b = r_x;
        if (mul_done) w_state_nxt = MYY;
      end
      MYY: begin
        mul_start   = 1'b1;
        mul_a       = r_y;
        mul_b       = r_y;
        w_state_nxt = WYY;
      end
      WYY: begin
        mul_a = r_y;
        mul_b = r_y;
        if (mul_done) w_state_nxt = MXY;
      end
      MXY: begin
        mul_start   = 1'b1;
        mul_a       = r_x;
        mul_b       = r_y;
        w_state_nxt = WXY;
      end
      WXY: begin
        mul_a = r_x;
        mul_b = r_y;
        if (mul_done) w_state_nxt = UPDATE;
      end
      UPDATE: begin
        if (w_escape || w_last) w_state_nxt = IDLE;
        else                    w_state_nxt = MXX;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cx       <= '0;
      r_cy       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_xx       <= '0;
      r_yy       <= '0;
      r_xy       <= '0;
      r_iter_max <= '0;
      r_iter     <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_escaped  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_start) begin
            r_cx       <= io_cx;
            r_cy       <= io_cy;
            r_iter_max <= io_iter_max;
            r_x        <= '0;
            r_y        <= '0;
            r_iter     <= '0;
            r_ovf      <= 1'b0;
            r_escaped  <= 1'b0;
            // A zero limit completes immediately without using the multiplier.
            if (io_iter_max == '0) r_done <= 1'b1;
            else                   r_busy <= 1'b1;
          end
        end
        WXX: begin
          if (mul_done) begin
            r_xx  <= mul_val;
            r_ovf <= r_ovf | mul_ovf;
          end
        end
        WYY: begin
          if (mul_done) begin
            r_yy  <= mul_val;
            r_ovf <= r_ovf | mul_ovf;
          end
        end
        WXY: begin
          if (mul_done) begin
            r_xy  <= mul_val;
            r_ovf <= r_ovf | mul_ovf;
          end
        end
        UPDATE: begin
          if (w_escape) begin
            r_escaped <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_x    <= w_nx[24:0];
            r_y    <= w_ny[24:0];
            r_iter <= w_iter_inc;
            if (w_last) begin
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_busy    = r_busy;
  assign io_done    = r_done;
  assign io_iter    = r_iter;
  assign io_escaped = r_escaped;

endmodule
